nway_cache_ctrl: RTL and testbench

NWAY_CACHE_CTRL -- requirements
Module: nway_cache_ctrl

---
 rtl/cache_pkg.sv | 29 ++
 rtl/lru_age_ctrl.sv | 38 +++
 rtl/nway_cache_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_nway_cache_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types, default sizes and address-field width helpers for the cache.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FILL      = 2'd2,
    ST_RESPOND   = 2'd3
  } state_t;

  localparam int unsigned DEF_NUM_SET = 4;
  localparam int unsigned DEF_NUM_WAY = 2;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned OFS_W       = 2;

  function automatic int unsigned idx_width(input int unsigned num_set);
    return $clog2(num_set);
  endfunction

  function automatic int unsigned tag_width(input int unsigned num_set);
    return ADDR_W - OFS_W - $clog2(num_set);
  endfunction

  function automatic int unsigned way_width(input int unsigned num_way);
    return $clog2(num_way);
  endfunction

endpackage

// File: rtl/lru_age_ctrl.sv
// Age-based LRU for one set: ages form a permutation of 0..NUM_WAY-1,
// the oldest way (age NUM_WAY-1) is the replacement victim.
module lru_age_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned NUM_WAY = DEF_NUM_WAY,
  localparam int unsigned WAY_W  = way_width(NUM_WAY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_touch,
  input  logic [WAY_W-1:0] i_way,
  output logic [WAY_W-1:0] o_victim
);

  logic [WAY_W-1:0] r_age [NUM_WAY];

  // Touched way becomes youngest; ways younger than its old age grow older by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned w = 0; w < NUM_WAY; w++) r_age[w] <= WAY_W'(w);
    end else if (i_touch) begin
      for (int unsigned w = 0; w < NUM_WAY; w++) begin
        if (WAY_W'(w) == i_way)          r_age[w] <= '0;
        else if (r_age[w] < r_age[i_way]) r_age[w] <= r_age[w] + WAY_W'(1);
      end
    end
  end

  // Victim is the way carrying the oldest age.
  always_comb begin
    o_victim = '0;
    for (int unsigned w = 0; w < NUM_WAY; w++) begin
      if (r_age[w] == WAY_W'(NUM_WAY - 1)) o_victim = WAY_W'(w);
    end
  end

endmodule

// File: rtl/nway_cache_ctrl.sv
// N-way set-associative write-back / write-allocate cache controller,
// one word per line, single outstanding CPU request.
module nway_cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned NUM_SET = DEF_NUM_SET,
  parameter int unsigned NUM_WAY = DEF_NUM_WAY,
  parameter int unsigned DATA_W  = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid
);

  localparam int unsigned IDX_W = idx_width(NUM_SET);
  localparam int unsigned TAG_W = tag_width(NUM_SET);
  localparam int unsigned WAY_W = way_width(NUM_WAY);

  state_t r_state, w_next;

  logic              r_valid [NUM_SET][NUM_WAY];
  logic              r_dirty [NUM_SET][NUM_WAY];
  logic [TAG_W-1:0]  r_tag   [NUM_SET][NUM_WAY];
  logic [DATA_W-1:0] r_data  [NUM_SET][NUM_WAY];

  logic              r_req_write;
  logic [DATA_W-1:0] r_req_wdata;
  logic [IDX_W-1:0]  r_req_idx;
  logic [TAG_W-1:0]  r_req_tag;
  logic [WAY_W-1:0]  r_way;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic [WAY_W-1:0]  w_hit_way;
  logic              w_inv_found;
  logic [WAY_W-1:0]  w_inv_way;
  logic [WAY_W-1:0]  w_victim_way;
  logic              w_victim_dirty;
  logic [WAY_W-1:0]  w_lru_victim [NUM_SET];
  logic              w_unused;

  assign w_idx    = req_addr[OFS_W +: IDX_W];
  assign w_tag    = req_addr[OFS_W + IDX_W +: TAG_W];
  assign w_unused = ^req_addr[OFS_W-1:0];

  // LRU state per set; ages advance once per completed request, in RESPOND.
  for (genvar s = 0; s < NUM_SET; s++) begin : g_lru
    lru_age_ctrl #(
      .NUM_WAY (NUM_WAY)
    ) u_lru (
      .clk      (clk),
      .rst      (rst),
      .i_touch  ((r_state == ST_RESPOND) && (r_req_idx == IDX_W'(s))),
      .i_way    (r_way),
      .o_victim (w_lru_victim[s])
    );
  end

  // Tag lookup for the incoming request plus victim choice (first invalid, else LRU).
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int unsigned w = 0; w < NUM_WAY; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!r_valid[w_idx][w] && !w_inv_found) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
    end
    w_victim_way   = w_inv_found ? w_inv_way : w_lru_victim[w_idx];
    w_victim_dirty = r_valid[w_idx][w_victim_way] && r_dirty[w_idx][w_victim_way];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_hit)               w_next = ST_RESPOND;
          else if (w_victim_dirty) w_next = ST_WRITEBACK;
          else if (!req_write)     w_next = ST_FILL;
          else                     w_next = ST_RESPOND;
        end
      end
      ST_WRITEBACK: if (mem_valid) w_next = r_req_write ? ST_RESPOND : ST_FILL;
      ST_FILL:      if (mem_valid) w_next = ST_RESPOND;
      ST_RESPOND:   w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // FSM outputs; all decoded from the registered state so reset drops them at once.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (r_state)
      ST_IDLE: req_ready = 1'b1;
      ST_WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {r_tag[r_req_idx][r_way], r_req_idx, 2'b00};
        mem_wdata = r_data[r_req_idx][r_way];
      end
      ST_FILL: begin
        mem_read = 1'b1;
        mem_addr = {r_req_tag, r_req_idx, 2'b00};
      end
      ST_RESPOND: begin
        resp_valid = 1'b1;
        if (!r_req_write) resp_rdata = r_data[r_req_idx][r_way];
      end
      default: ;
    endcase
  end

  // Request latch and line storage updates.
  // A store miss into a clean victim installs the full word immediately, and a
  // store after write-back overwrites the victim in the same cycle it is cleaned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_write <= 1'b0;
      r_req_wdata <= '0;
      r_req_idx   <= '0;
      r_req_tag   <= '0;
      r_way       <= '0;
      for (int unsigned s = 0; s < NUM_SET; s++) begin
        for (int unsigned w = 0; w < NUM_WAY; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_tag[s][w]   <= '0;
          r_data[s][w]  <= '0;
        end
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_req_write <= req_write;
            r_req_wdata <= req_wdata;
            r_req_idx   <= w_idx;
            r_req_tag   <= w_tag;
            if (w_hit) begin
              r_way <= w_hit_way;
              if (req_write) begin
                r_data[w_idx][w_hit_way]  <= req_wdata;
                r_dirty[w_idx][w_hit_way] <= 1'b1;
              end
            end else begin
              r_way <= w_victim_way;
              if (req_write && !w_victim_dirty) begin
                r_valid[w_idx][w_victim_way] <= 1'b1;
                r_dirty[w_idx][w_victim_way] <= 1'b1;
                r_tag[w_idx][w_victim_way]   <= w_tag;
                r_data[w_idx][w_victim_way]  <= req_wdata;
              end
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_valid) begin
            if (r_req_write) begin
              r_valid[r_req_idx][r_way] <= 1'b1;
              r_dirty[r_req_idx][r_way] <= 1'b1;
              r_tag[r_req_idx][r_way]   <= r_req_tag;
              r_data[r_req_idx][r_way]  <= r_req_wdata;
            end else begin
              r_dirty[r_req_idx][r_way] <= 1'b0;
            end
          end
        end
        ST_FILL: begin
          if (mem_valid) begin
            r_valid[r_req_idx][r_way] <= 1'b1;
            r_dirty[r_req_idx][r_way] <= 1'b0;
            r_tag[r_req_idx][r_way]   <= r_req_tag;
            r_data[r_req_idx][r_way]  <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nway_cache_ctrl.sv
// Directed bench for nway_cache_ctrl (NUM_SET=4, NUM_WAY=2) with a simple
// latency-programmable backing-memory responder inside the request task.
module tb_nway_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write, mem_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  // Results of the most recent do_req call.
  logic [31:0] t_rdata, t_wb_addr, t_wb_data, t_rd_addr;
  int          t_nrd, t_nwr, t_lat, t_acc;
  bit          t_resp, t_both;

  nway_cache_ctrl #(
    .NUM_SET (4),
    .NUM_WAY (2),
    .DATA_W  (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_valid  (mem_valid)
  );

  always #5 clk = ~clk;

  // Issue one request (called 1ns after a rising edge, DUT in IDLE), play memory
  // with mlat cycles per burst, and record traffic and the response.
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] fill, input int mlat, input bit hold);
    int cnt;
    bit prev_rd, prev_wr;
    t_rdata = '0; t_wb_addr = '0; t_wb_data = '0; t_rd_addr = '0;
    t_nrd = 0; t_nwr = 0; t_lat = -1; t_resp = 0; t_both = 0;
    cnt = 0; prev_rd = 0; prev_wr = 0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; mem_rdata = fill;
    t_acc = req_ready ? 1 : 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      mem_valid = 1'b0;
      if (!hold) req_valid = 1'b0;
      else if (req_valid && req_ready) t_acc++;
      if (mem_read && mem_write) t_both = 1;
      if (mem_read) begin
        if (!prev_rd) begin t_nrd++; t_rd_addr = mem_addr; cnt = 0; end
        cnt++;
        if (cnt == mlat) mem_valid = 1'b1;
      end
      if (mem_write) begin
        if (!prev_wr) begin t_nwr++; t_wb_addr = mem_addr; t_wb_data = mem_wdata; cnt = 0; end
        cnt++;
        if (cnt == mlat) mem_valid = 1'b1;
      end
      prev_rd = mem_read; prev_wr = mem_write;
      if (resp_valid) begin
        t_resp = 1; t_rdata = resp_rdata; t_lat = c; req_valid = 1'b0;
        break;
      end
    end
    req_valid = 1'b0;
    mem_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mem_read !== 1'b0)  begin errors++; $display("FAIL rst_mem_read: got %b want 0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write: got %b want 0", mem_write); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1)   begin errors++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0)  begin errors++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    checks++; if (mem_addr !== 32'h0)   begin errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0)  begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
  endtask

  task automatic test_cold_load();
    do_req(1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_0001, 3, 1'b0);
    checks++; if (t_resp !== 1'b1)          begin errors++; $display("FAIL cold_resp: got %b want 1", t_resp); end
    checks++; if (t_nrd != 1)               begin errors++; $display("FAIL cold_nrd: got %0d want 1", t_nrd); end
    checks++; if (t_nwr != 0)               begin errors++; $display("FAIL cold_nwr: got %0d want 0", t_nwr); end
    checks++; if (t_rd_addr !== 32'h10)     begin errors++; $display("FAIL cold_rd_addr: got %h want 00000010", t_rd_addr); end
    checks++; if (t_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL cold_rdata: got %h want cafe0001", t_rdata); end
    do_req(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_DEAD, 3, 1'b0);
    checks++; if (t_lat != 0)               begin errors++; $display("FAIL hit_latency: got %0d want 0", t_lat); end
    checks++; if (t_nrd != 0)               begin errors++; $display("FAIL hit_nrd: got %0d want 0", t_nrd); end
    checks++; if (t_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL hit_rdata: got %h want cafe0001", t_rdata); end
  endtask

  task automatic test_store_hit();
    do_req(1'b1, 32'h0000_0010, 32'h1111_2222, 32'hDEAD_DEAD, 2, 1'b0);
    checks++; if (t_lat != 0)               begin errors++; $display("FAIL sthit_latency: got %0d want 0", t_lat); end
    checks++; if (t_nrd + t_nwr != 0)       begin errors++; $display("FAIL sthit_traffic: got %0d want 0", t_nrd + t_nwr); end
    do_req(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_DEAD, 2, 1'b0);
    checks++; if (t_nrd + t_nwr != 0)       begin errors++; $display("FAIL sthit_ld_traffic: got %0d want 0", t_nrd + t_nwr); end
    checks++; if (t_rdata !== 32'h1111_2222) begin errors++; $display("FAIL sthit_rdata: got %h want 11112222", t_rdata); end
  endtask

  task automatic test_writeback();
    do_req(1'b1, 32'h0000_0050, 32'h5555_0005, 32'hDEAD_DEAD, 2, 1'b0);
    checks++; if (t_nrd + t_nwr != 0)       begin errors++; $display("FAIL wb_st50_traffic: got %0d want 0", t_nrd + t_nwr); end
    do_req(1'b0, 32'h0000_0090, 32'h0, 32'h9999_0009, 2, 1'b0);
    checks++; if (t_nwr != 1)               begin errors++; $display("FAIL wb_nwr: got %0d want 1", t_nwr); end
    checks++; if (t_wb_addr !== 32'h10)     begin errors++; $display("FAIL wb_addr: got %h want 00000010", t_wb_addr); end
    checks++; if (t_wb_data !== 32'h1111_2222) begin errors++; $display("FAIL wb_data: got %h want 11112222", t_wb_data); end
    checks++; if (t_nrd != 1)               begin errors++; $display("FAIL wb_fill_nrd: got %0d want 1", t_nrd); end
    checks++; if (t_rd_addr !== 32'h90)     begin errors++; $display("FAIL wb_fill_addr: got %h want 00000090", t_rd_addr); end
    checks++; if (t_rdata !== 32'h9999_0009) begin errors++; $display("FAIL wb_rdata: got %h want 99990009", t_rdata); end
    do_req(1'b0, 32'h0000_0050, 32'h0, 32'hDEAD_DEAD, 2, 1'b0);
    checks++; if (t_nrd + t_nwr != 0)       begin errors++; $display("FAIL wb_ld50_traffic: got %0d want 0", t_nrd + t_nwr); end
    checks++; if (t_rdata !== 32'h5555_0005) begin errors++; $display("FAIL wb_ld50_rdata: got %h want 55550005", t_rdata); end
    // way holding clean 0x90 is now LRU: plain fill, no write-back
    do_req(1'b0, 32'h0000_0010, 32'h0, 32'h1010_1010, 2, 1'b0);
    checks++; if (t_nwr != 0)               begin errors++; $display("FAIL lru_clean_nwr: got %0d want 0", t_nwr); end
    checks++; if (t_nrd != 1)               begin errors++; $display("FAIL lru_clean_nrd: got %0d want 1", t_nrd); end
    checks++; if (t_rdata !== 32'h1010_1010) begin errors++; $display("FAIL lru_clean_rdata: got %h want 10101010", t_rdata); end
  endtask

  task automatic test_store_miss();
    do_req(1'b1, 32'h0000_0024, 32'h2424_2424, 32'hDEAD_DEAD, 2, 1'b0);
    checks++; if (t_nrd != 0)               begin errors++; $display("FAIL stmiss_nrd: got %0d want 0", t_nrd); end
    checks++; if (t_resp !== 1'b1)          begin errors++; $display("FAIL stmiss_resp: got %b want 1", t_resp); end
    do_req(1'b0, 32'h0000_0024, 32'h0, 32'hDEAD_DEAD, 2, 1'b0);
    checks++; if (t_nrd + t_nwr != 0)       begin errors++; $display("FAIL stmiss_ld_traffic: got %0d want 0", t_nrd + t_nwr); end
    checks++; if (t_rdata !== 32'h2424_2424) begin errors++; $display("FAIL stmiss_rdata: got %h want 24242424", t_rdata); end
  endtask

  task automatic test_back_to_back();
    do_req(1'b0, 32'h0000_0064, 32'h0, 32'h6464_0064, 4, 1'b1);
    checks++; if (t_acc != 1)               begin errors++; $display("FAIL hold_accepts: got %0d want 1", t_acc); end
    checks++; if (t_both !== 1'b0)          begin errors++; $display("FAIL hold_both_strobes: got %b want 0", t_both); end
    checks++; if (t_nrd != 1)               begin errors++; $display("FAIL hold_nrd: got %0d want 1", t_nrd); end
    checks++; if (t_rdata !== 32'h6464_0064) begin errors++; $display("FAIL hold_rdata: got %h want 64640064", t_rdata); end
  endtask

  task automatic test_reset_mid_fill();
    bit seen;
    seen = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0038; mem_rdata = 32'hBAD0_BAD0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (mem_read) begin seen = 1; break; end
    end
    req_valid = 1'b0;
    checks++; if (seen !== 1'b1)   begin errors++; $display("FAIL midrst_fill_seen: got %b want 1", seen); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL midrst_mem_read: got %b want 0", mem_read); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL midrst_mem_addr: got %h want 0", mem_addr); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_req(1'b0, 32'h0000_0010, 32'h0, 32'hA0A0_0010, 2, 1'b0);
    checks++; if (t_nrd != 1)              begin errors++; $display("FAIL midrst_miss_nrd: got %0d want 1", t_nrd); end
    checks++; if (t_nwr != 0)              begin errors++; $display("FAIL midrst_miss_nwr: got %0d want 0", t_nwr); end
    checks++; if (t_rdata !== 32'hA0A0_0010) begin errors++; $display("FAIL midrst_rdata: got %h want a0a00010", t_rdata); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    mem_valid = 1'b0; mem_rdata = '0;
    test_reset();
    test_cold_load();
    test_store_hit();
    test_writeback();
    test_store_miss();
    test_back_to_back();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
